// File: rtl/nybble_prefetch.sv
// nybble_prefetch
//   Instruction-byte prefetcher for the nybble CPU core. Fetches opcode bytes
//   from a byte-wide, variable-latency memory port into a small FIFO and hands
//   them to decode in order, each tagged with its byte address. Core control
//   flow restarts the fetch stream through redirect/redirect_addr.
//
// Ports
//   clock, reset_n          single clock, asynchronous active-low reset
//   redirect, redirect_addr restart fetching at redirect_addr (flushes FIFO)
//   mem_req, mem_addr       registered read request; held stable until mem_ack
//   mem_ack, mem_rdata      read completion and data (ack may come the same
//                           cycle mem_req rises)
//   ins_valid, ins_byte,    FIFO head: byte and its address
//   ins_addr
//   ins_ready               core consumes the head on this edge if ins_valid
module nybble_prefetch #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              ins_valid,
  output logic [7:0]        ins_byte,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic              ins_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // IDLE : nothing in flight
  // REQ  : live request in flight; its data is pushed on ack
  // DRAIN: request made stale by a redirect; its data is dropped on ack
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] f, f_next;
  logic [CW-1:0]     count, count_next;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [7:0]        fifo_byte [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic              push, pop, issue_slot;
  logic              mem_req_next;
  logic [ADDR_W-1:0] mem_addr_next;

  assign ins_valid = (count != '0);
  assign ins_byte  = fifo_byte[rd_ptr];
  assign ins_addr  = fifo_addr[rd_ptr];

  // Redirect wins over both FIFO operations on the same edge.
  assign push = (state == REQ) && mem_ack && !redirect;
  assign pop  = ins_valid && ins_ready && !redirect;

  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
    f_next = f;
    if (redirect) begin
      f_next = redirect_addr;
    end else if (push) begin
      f_next = f + ADDR_W'(1);
    end
  end

  // issue_slot marks an edge that leaves nothing in flight; the issue decision
  // then looks at post-edge occupancy so requests run back-to-back while the
  // FIFO has room and the FIFO can never overflow.
  always_comb begin
    state_next    = state;
    mem_req_next  = mem_req;
    mem_addr_next = mem_addr;
    issue_slot    = 1'b0;
    case (state)
      IDLE: issue_slot = 1'b1;
      REQ: begin
        if (mem_ack) begin
          issue_slot = 1'b1;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          issue_slot = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (issue_slot) begin
      if (count_next < CW'(DEPTH)) begin
        state_next    = REQ;
        mem_req_next  = 1'b1;
        mem_addr_next = f_next;
      end else begin
        state_next    = IDLE;
        mem_req_next  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      f        <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_next;
      f        <= f_next;
      count    <= count_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_byte[wr_ptr] <= mem_rdata;
      fifo_addr[wr_ptr] <= f;
    end
  end

endmodule

// File: tb/tb_nybble_prefetch.sv
// tb_nybble_prefetch
//   Directed bench for nybble_prefetch. A queue-based reference model of the
//   prefetcher (pending request, stale flag, fetch pointer, byte FIFO) is
//   stepped on every clock edge and compared against the DUT outputs on every
//   falling edge. A memory responder acks each request after ack_delay cycles
//   with data = address[7:0]. Hand-computed literal expectations pin the
//   reset, streaming, back-pressure, redirect, collision and wrap scenarios.
module tb_nybble_prefetch;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clock;
  logic              reset_n;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              ins_valid;
  logic [7:0]        ins_byte;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_ready;

  nybble_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ins_valid    (ins_valid),
    .ins_byte     (ins_byte),
    .ins_addr     (ins_addr),
    .ins_ready    (ins_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [15:0] q_addr[$];
  logic [7:0]  q_byte[$];
  logic [15:0] m_f;
  logic [15:0] m_addr;
  bit          m_req;
  bit          m_stale;
  int unsigned wait_cnt;
  int unsigned ack_delay;

  int total;
  int passed;
  int cyc;

  // Observation logs
  logic [15:0] log_addr[$];
  logic [7:0]  log_byte[$];
  int          log_cyc[$];
  int          ack_cnt;
  logic [15:0] ack_addr[$];
  bit          last_coll;

  logic [15:0] wrap_addr [4];
  logic [7:0]  wrap_byte [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_byte.delete();
    m_f      = '0;
    m_addr   = '0;
    m_req    = 1'b0;
    m_stale  = 1'b0;
    wait_cnt = 0;
  endtask

  // One clock edge of the prefetcher, stated as the fetch rules themselves.
  task automatic model_update();
    bit ack;
    bit do_pop;
    ack    = m_req && mem_ack;
    do_pop = (q_addr.size() != 0) && ins_ready;
    if (redirect) begin
      q_addr.delete();
      q_byte.delete();
      m_f = redirect_addr;
      if (m_req && !ack) m_stale = 1'b1;
    end else begin
      if (do_pop) begin
        void'(q_addr.pop_front());
        void'(q_byte.pop_front());
      end
      if (ack && !m_stale) begin
        q_addr.push_back(m_f);
        q_byte.push_back(mem_rdata);
        m_f = m_f + 16'd1;
      end
    end
    if (!m_req || ack) begin
      m_stale  = 1'b0;
      wait_cnt = 0;
      if (q_addr.size() < DEPTH) begin
        m_req  = 1'b1;
        m_addr = m_f;
      end else begin
        m_req = 1'b0;
      end
    end else begin
      wait_cnt++;
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("ins_valid", 32'(ins_valid), 32'(q_addr.size() != 0));
    if (q_addr.size() != 0) begin
      chk("ins_byte", 32'(ins_byte), 32'(q_byte[0]));
      chk("ins_addr", 32'(ins_addr), 32'(q_addr[0]));
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    check_outputs();
    if (m_req && wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = m_addr[7:0];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h5A;
    end
    last_coll = m_req && mem_ack && ins_valid && ins_ready;
    if (m_req && mem_ack) begin
      ack_cnt++;
      ack_addr.push_back(mem_addr);
    end
    if (ins_valid && ins_ready && !redirect) begin
      log_addr.push_back(ins_addr);
      log_byte.push_back(ins_byte);
      log_cyc.push_back(cyc);
    end
    @(posedge clock);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    mem_ack  = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_byte.delete();
    log_cyc.delete();
  endtask

  initial begin
    reset_n       = 1'b1;
    redirect      = 1'b0;
    redirect_addr = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    ins_ready     = 1'b0;
    ack_delay     = 0;
    total         = 0;
    passed        = 0;
    cyc           = 0;
    ack_cnt       = 0;
    last_coll     = 1'b0;
    wrap_addr     = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    wrap_byte     = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    model_reset();
    #1;

    // Reset, then reset again while a request is outstanding
    ack_delay = 3;
    do_reset();
    repeat (2) cycle();
    chk("t1_req_pending", 32'(mem_req), 32'd1);
    do_reset();
    ack_delay = 0;
    ins_ready = 1'b1;
    clear_logs();
    cycle();
    chk("t1_first_req", 32'(mem_req), 32'd1);
    chk("t1_first_addr", 32'(mem_addr), 32'h0000);

    // Streaming with same-cycle acks
    repeat (11) cycle();
    chk("t2_pop_count", 32'(log_addr.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i < log_addr.size()) begin
        chk("t2_addr", 32'(log_addr[i]), 32'(i));
        chk("t2_byte", 32'(log_byte[i]), 32'(i));
        chk("t2_no_gap", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
      end
    end

    // Full FIFO and back-pressure
    ins_ready = 1'b0;
    do_reset();
    ack_cnt = 0;
    ack_addr.delete();
    repeat (8) cycle();
    chk("t3_acks_to_full", 32'(ack_cnt), 32'd4);
    chk("t3_req_low", 32'(mem_req), 32'd0);
    ins_ready = 1'b1;
    cycle();
    ins_ready = 1'b0;
    chk("t3_reissue", 32'(mem_req), 32'd1);
    chk("t3_reissue_addr", 32'(mem_addr), 32'h0004);
    ack_cnt = 0;
    ack_addr.delete();
    repeat (6) cycle();
    chk("t3_one_more_ack", 32'(ack_cnt), 32'd1);
    if (ack_addr.size() != 0) chk("t3_ack_addr", 32'(ack_addr[0]), 32'h0004);
    chk("t3_req_low2", 32'(mem_req), 32'd0);

    // Redirect while a slow request is outstanding
    ack_delay     = 3;
    redirect      = 1'b1;
    redirect_addr = 16'h0010;
    cycle();
    redirect = 1'b0;
    chk("t4_req_addr", 32'(mem_addr), 32'h0010);
    cycle();
    redirect      = 1'b1;
    redirect_addr = 16'h0200;
    cycle();
    redirect = 1'b0;
    chk("t4_hold_req", 32'(mem_req), 32'd1);
    chk("t4_hold1", 32'(mem_addr), 32'h0010);
    cycle();
    chk("t4_hold2", 32'(mem_addr), 32'h0010);
    chk("t4_no_stale", 32'(ins_valid), 32'd0);
    cycle();
    chk("t4_next_addr", 32'(mem_addr), 32'h0200);
    ins_ready = 1'b1;
    ack_delay = 0;
    clear_logs();
    repeat (4) cycle();
    if (log_addr.size() != 0) chk("t4_first_ins_addr", 32'(log_addr[0]), 32'h0200);
    else chk("t4_first_ins_seen", 32'd0, 32'd1);

    // Redirect colliding with ack and pop; then two redirects while draining
    redirect      = 1'b1;
    redirect_addr = 16'h0300;
    cycle();
    redirect = 1'b0;
    chk("t5_collision", 32'(last_coll), 32'd1);
    chk("t5_flushed", 32'(ins_valid), 32'd0);
    chk("t5_req", 32'(mem_req), 32'd1);
    chk("t5_addr", 32'(mem_addr), 32'h0300);
    ack_delay = 3;
    cycle();
    redirect      = 1'b1;
    redirect_addr = 16'h0400;
    cycle();
    redirect_addr = 16'h0500;
    cycle();
    redirect = 1'b0;
    chk("t5_drain_hold", 32'(mem_addr), 32'h0300);
    cycle();
    chk("t5_last_wins", 32'(mem_addr), 32'h0500);
    ack_delay = 0;
    clear_logs();
    repeat (4) cycle();
    if (log_addr.size() != 0) chk("t5_first_ins_addr", 32'(log_addr[0]), 32'h0500);
    else chk("t5_first_ins_seen", 32'd0, 32'd1);

    // Address wrap
    redirect      = 1'b1;
    redirect_addr = 16'hFFFE;
    clear_logs();
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();
    chk("t6_pop_count", 32'(log_addr.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        chk("t6_wrap_addr", 32'(log_addr[i]), 32'(wrap_addr[i]));
        chk("t6_wrap_byte", 32'(log_byte[i]), 32'(wrap_byte[i]));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
